reflet_float_fisqrt_arbiter: RTL and testbench

REFLET_FLOAT_FISQRT_ARBITER -- requirements
Module: reflet_float_fisqrt_arbiter

---
 rtl/reflet_fpu_pkg.sv | 17 +
 rtl/reflet_rr_picker.sv | 36 +++
 rtl/reflet_float_fisqrt_arbiter.sv | 120 ++++++++++++
 tb/tb_reflet_float_fisqrt_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reflet_fpu_pkg.sv
// Shared FPU definitions: arbiter state encoding, default float width, index-width helper.
package reflet_fpu_pkg;

  localparam int unsigned float_size_default = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } fisqrt_arb_state_t;

  // Width of an index into n entries; a single entry still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reflet_rr_picker.sv
// Round-robin picker: first set request bit strictly after last_grant, wrapping to 0.
module reflet_rr_picker
  import reflet_fpu_pkg::*;
#(
  parameter int unsigned nb_req = 4,
  localparam int unsigned idx_w = idx_width(nb_req)
) (
  input  logic [nb_req-1:0] req,
  input  logic [idx_w-1:0]  last_grant,
  output logic              valid,
  output logic [idx_w-1:0]  index
);

  logic [2**idx_w-1:0] req_ext;
  logic [idx_w-1:0]    cand;
  int unsigned         pos;

  always_comb begin
    req_ext              = '0;
    req_ext[nb_req-1:0]  = req;
    valid                = 1'b0;
    index                = '0;
    cand                 = '0;
    pos                  = 0;
    for (int unsigned off = 1; off <= nb_req; off++) begin
      pos = 32'(last_grant) + off;
      if (pos >= nb_req) pos = pos - nb_req;
      cand = idx_w'(pos);
      if (!valid && req_ext[cand]) begin
        valid = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/reflet_float_fisqrt_arbiter.sv
// Shares one external reflet_float_fisqrt among nb_req requesters (round-robin).
// Optional watchdog on the shared unit: define REFLET_FISQRT_ARB_TIMEOUT_EN.
module reflet_float_fisqrt_arbiter
  import reflet_fpu_pkg::*;
#(
  parameter int unsigned float_size = float_size_default,
  parameter int unsigned nb_req     = 4,
  parameter int unsigned timeout    = 255
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [nb_req-1:0]            req,
  input  logic [nb_req*float_size-1:0] req_in,
  output logic [nb_req-1:0]            done,
  output logic [float_size-1:0]        result,
  output logic                         fisqrt_enable,
  output logic [float_size-1:0]        fisqrt_in,
  input  logic                         fisqrt_ready,
  input  logic [float_size-1:0]        fisqrt_out,
  output logic                         busy
`ifdef REFLET_FISQRT_ARB_TIMEOUT_EN
  ,
  output logic [nb_req-1:0]            error
`endif
);

  localparam int unsigned idx_w = idx_width(nb_req);

  if (nb_req < 1 || nb_req > 16 || timeout < 1) begin : g_cfg_check
    $error("reflet_float_fisqrt_arbiter: unsupported nb_req or timeout");
  end

  fisqrt_arb_state_t       state;
  logic [idx_w-1:0]        grant;
  logic [idx_w-1:0]        last_grant;
  logic                    pick_valid;
  logic [idx_w-1:0]        pick_idx;
  logic [float_size-1:0]   pick_op;

  reflet_rr_picker #(.nb_req(nb_req)) u_picker (
    .req        (req),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .index      (pick_idx)
  );

  always_comb begin
    pick_op = '0;
    for (int unsigned i = 0; i < nb_req; i++) begin
      if (pick_idx == idx_w'(i)) pick_op = req_in[i*float_size +: float_size];
    end
  end

`ifdef REFLET_FISQRT_ARB_TIMEOUT_EN
  localparam int unsigned cnt_w = idx_width(timeout);
  logic [cnt_w-1:0] wait_cnt;
`endif

  // fisqrt_in doubles as the latched operand, so it stays stable for all of ISSUE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      done          <= '0;
      result        <= '0;
      fisqrt_enable <= 1'b0;
      fisqrt_in     <= '0;
      busy          <= 1'b0;
      grant         <= '0;
      last_grant    <= idx_w'(nb_req - 1);
`ifdef REFLET_FISQRT_ARB_TIMEOUT_EN
      error         <= '0;
      wait_cnt      <= '0;
`endif
    end else begin
      done <= '0;
`ifdef REFLET_FISQRT_ARB_TIMEOUT_EN
      error <= '0;
`endif
      unique case (state)
        IDLE: begin
          if (pick_valid) begin
            grant         <= pick_idx;
            fisqrt_in     <= pick_op;
            fisqrt_enable <= 1'b1;
            busy          <= 1'b1;
            state         <= ISSUE;
`ifdef REFLET_FISQRT_ARB_TIMEOUT_EN
            wait_cnt      <= '0;
`endif
          end
        end
        ISSUE: begin
          if (fisqrt_ready) begin
            result        <= fisqrt_out;
            done[grant]   <= 1'b1;
            last_grant    <= grant;
            fisqrt_enable <= 1'b0;
            state         <= DONE;
          end
`ifdef REFLET_FISQRT_ARB_TIMEOUT_EN
          else if (wait_cnt == cnt_w'(timeout - 1)) begin
            error[grant]  <= 1'b1;
            last_grant    <= grant;
            fisqrt_enable <= 1'b0;
            state         <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reflet_float_fisqrt_arbiter.sv
// Self-checking bench: behavioural shared-unit model plus round-robin reference model.
module tb_reflet_float_fisqrt_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req;
  logic [31:0]  ops [4];
  logic [127:0] req_in;
  logic [3:0]   done;
  logic [31:0]  result;
  logic         fisqrt_enable;
  logic [31:0]  fisqrt_in;
  logic         fisqrt_ready;
  logic [31:0]  fisqrt_out;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int model_last = 3;

  int unsigned lat = 0;
  logic        stall = 1'b0;
  logic        force_ready = 1'b0;
  int unsigned ucnt = 0;

  always #5 clk = ~clk;

  assign req_in = {ops[3], ops[2], ops[1], ops[0]};

  function automatic logic [31:0] unit_fn(input logic [31:0] x);
    if (x == 32'h4080_0000) return 32'h3F00_0000;
    return {x[31:16] ^ 16'h5F37, x[15:0] + 16'h1234};
  endfunction

  function automatic int next_rr(input int last, input logic [3:0] m);
    for (int k = 1; k <= 4; k++) begin
      if (m[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  // Shared unit: ready after lat further cycles of continuous enable.
  always @(posedge clk) begin
    if (!fisqrt_enable) ucnt <= 0;
    else if (ucnt < 1000) ucnt <= ucnt + 1;
  end
  assign fisqrt_ready = force_ready || (fisqrt_enable && !stall && ucnt >= lat);
  assign fisqrt_out   = unit_fn(fisqrt_in);

  reflet_float_fisqrt_arbiter #(
    .float_size (32),
    .nb_req     (4),
    .timeout    (255)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .req_in        (req_in),
    .done          (done),
    .result        (result),
    .fisqrt_enable (fisqrt_enable),
    .fisqrt_in     (fisqrt_in),
    .fisqrt_ready  (fisqrt_ready),
    .fisqrt_out    (fisqrt_out),
    .busy          (busy)
  );

  task automatic wait_done(input int budget, output int idx, output int cyc);
    idx = -2;
    cyc = 0;
    while (cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (done !== 4'b0000) begin
        idx = -1;
        for (int b = 0; b < 4; b++) if (done === (4'b0001 << b)) idx = b;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL wait_done: no done pulse within %0d cycles", budget);
  endtask

  task automatic wait_enable(input int budget);
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (fisqrt_enable === 1'b1) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_enable: fisqrt_enable never rose within %0d cycles", budget);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = 4'b0000;
    for (int i = 0; i < 4; i++) ops[i] = $urandom;
    repeat (3) @(negedge clk);
    checks++; if (done !== 4'b0000) begin errors++; $display("FAIL reset_done: got %b want 0000", done); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 0", result); end
    checks++; if (fisqrt_enable !== 1'b0) begin errors++; $display("FAIL reset_enable: got %b want 0", fisqrt_enable); end
    checks++; if (fisqrt_in !== 32'h0) begin errors++; $display("FAIL reset_fisqrt_in: got %h want 0", fisqrt_in); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    reset = 1'b0;
    model_last = 3;
    @(negedge clk);
  endtask

  task automatic test_all_four();
    int idx, cyc, exp;
    for (int i = 0; i < 4; i++) ops[i] = $urandom;
    lat = $urandom_range(0, 4);
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_done(40, idx, cyc);
      exp = next_rr(model_last, 4'b1111);
      checks++; if (idx !== exp) begin errors++; $display("FAIL all4_order[%0d]: got %0d want %0d", n, idx, exp); end
      checks++; if (result !== unit_fn(ops[exp])) begin errors++; $display("FAIL all4_result[%0d]: got %h want %h", n, result, unit_fn(ops[exp])); end
      if (n > 0) begin
        checks++; if (cyc != int'(lat) + 3) begin errors++; $display("FAIL all4_spacing[%0d]: got %0d want %0d", n, cyc, lat + 3); end
      end
      model_last = exp;
    end
    req = 4'b0000;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    int idx, cyc;
    ops[0] = 32'h4080_0000;
    lat = 2;
    req = 4'b0001;
    wait_done(40, idx, cyc);
    req = 4'b0000;
    checks++; if (done !== 4'b0001) begin errors++; $display("FAIL single_done: got %b want 0001", done); end
    checks++; if (result !== 32'h3F00_0000) begin errors++; $display("FAIL single_result: got %h want 3f000000", result); end
    @(negedge clk);
    checks++; if (done !== 4'b0000) begin errors++; $display("FAIL single_pulse: got %b want 0000", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %b want 0", busy); end
    model_last = 0;
    @(negedge clk);
  endtask

  task automatic test_latency();
    int en_cnt = 0;
    int bad_in = 0;
    int c = 0;
    ops[1] = $urandom;
    lat = 5;
    req = 4'b0010;
    while (c < 50 && done === 4'b0000) begin
      @(negedge clk);
      c++;
      if (fisqrt_enable === 1'b1) begin
        en_cnt++;
        if (fisqrt_in !== ops[1]) bad_in++;
      end
    end
    req = 4'b0000;
    checks++; if (done !== 4'b0010) begin errors++; $display("FAIL lat_done: got %b want 0010", done); end
    checks++; if (en_cnt != 6) begin errors++; $display("FAIL lat_enable_cycles: got %0d want 6", en_cnt); end
    checks++; if (bad_in != 0) begin errors++; $display("FAIL lat_operand_stable: got %0d bad cycles want 0", bad_in); end
    checks++; if (fisqrt_enable !== 1'b0) begin errors++; $display("FAIL lat_done_enable: got %b want 0", fisqrt_enable); end
    checks++; if (result !== unit_fn(ops[1])) begin errors++; $display("FAIL lat_result: got %h want %h", result, unit_fn(ops[1])); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || fisqrt_enable !== 1'b0) begin errors++; $display("FAIL lat_idle: got busy=%b en=%b want 0 0", busy, fisqrt_enable); end
    model_last = 1;
    @(negedge clk);
  endtask

  task automatic test_fairness();
    int idx, cyc, exp;
    lat = 3;
    ops[0] = $urandom;
    ops[2] = $urandom;
    req = 4'b0001;
    wait_enable(20);
    req = 4'b0101;
    wait_done(40, idx, cyc);
    exp = next_rr(model_last, 4'b0001);
    checks++; if (idx !== exp) begin errors++; $display("FAIL fair_first: got %0d want %0d", idx, exp); end
    model_last = exp;
    wait_done(40, idx, cyc);
    exp = next_rr(model_last, 4'b0101);
    req = 4'b0000;
    checks++; if (idx !== exp) begin errors++; $display("FAIL fair_second: got %0d want %0d", idx, exp); end
    checks++; if (result !== unit_fn(ops[2])) begin errors++; $display("FAIL fair_result: got %h want %h", result, unit_fn(ops[2])); end
    model_last = exp;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_drop_req();
    int idx, cyc;
    lat = 4;
    ops[3] = $urandom;
    req = 4'b1000;
    wait_enable(20);
    req = 4'b0000;
    wait_done(40, idx, cyc);
    checks++; if (idx !== 3) begin errors++; $display("FAIL drop_done: got %0d want 3", idx); end
    checks++; if (result !== unit_fn(ops[3])) begin errors++; $display("FAIL drop_result: got %h want %h", result, unit_fn(ops[3])); end
    model_last = 3;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_ignore_ready();
    int bad = 0;
    req = 4'b0000;
    force_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (done !== 4'b0000 || busy !== 1'b0 || fisqrt_enable !== 1'b0) bad++;
    end
    force_ready = 1'b0;
    checks++; if (bad != 0) begin errors++; $display("FAIL idle_ready_ignored: got %0d bad cycles want 0", bad); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int idx, cyc, exp;
    int stray = 0;
    stall = 1'b1;
    lat = 1;
    req = 4'b0010;
    wait_enable(20);
    repeat (2) begin
      @(negedge clk);
      if (done !== 4'b0000) stray++;
    end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (fisqrt_enable !== 1'b0) begin errors++; $display("FAIL rstmid_enable: got %b want 0", fisqrt_enable); end
    checks++; if (done !== 4'b0000 || stray != 0) begin errors++; $display("FAIL rstmid_no_done: got %b (stray %0d) want 0000", done, stray); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    reset = 1'b0;
    stall = 1'b0;
    model_last = 3;
    for (int i = 0; i < 4; i++) ops[i] = $urandom;
    req = 4'b1111;
    wait_done(40, idx, cyc);
    req = 4'b0000;
    exp = next_rr(model_last, 4'b1111);
    checks++; if (idx !== exp) begin errors++; $display("FAIL rstmid_next_grant: got %0d want %0d", idx, exp); end
    checks++; if (result !== unit_fn(ops[exp])) begin errors++; $display("FAIL rstmid_result: got %h want %h", result, unit_fn(ops[exp])); end
    model_last = exp;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    int idx, cyc, exp;
    logic [3:0] m;
    for (int n = 0; n < 12; n++) begin
      m = 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++) ops[i] = $urandom;
      lat = $urandom_range(0, 6);
      exp = next_rr(model_last, m);
      req = m;
      wait_done(40, idx, cyc);
      req = 4'b0000;
      checks++; if (idx !== exp) begin errors++; $display("FAIL rand_grant[%0d]: got %0d want %0d (mask %b)", n, idx, exp, m); end
      checks++; if (result !== unit_fn(ops[exp])) begin errors++; $display("FAIL rand_result[%0d]: got %h want %h", n, result, unit_fn(ops[exp])); end
      model_last = exp;
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1;
    req   = 4'b0000;
    for (int i = 0; i < 4; i++) ops[i] = '0;
    test_reset();
    test_all_four();
    test_single();
    test_latency();
    test_fairness();
    test_drop_req();
    test_ignore_ready();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
